ysyx_22041071_store_buf: RTL and testbench
==========================================

YSYX_22041071_STORE_BUF -- requirements
Module: ysyx_22041071_store_buf

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, entry count, power of two from 2 to 16; ADDR_W, 64, address width; DATA_W, 64, data width; ID_W, 4, AXI ID width; ID, 4'd1, AXI ID driven on writes; LEN_W, 8, burst length width.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 st_valid  in  1  LSU store request valid.
REQ-005 st_ready  out  1  buffer can accept a store.
REQ-006 st_addr  in  ADDR_W  store byte address.
REQ-007 st_size  in  2  store size: 00=1B, 01=2B, 10=4B, 11=8B.
REQ-008 st_data  in  DATA_W  store data, LSB-aligned, unshifted.
REQ-009 wr_valid  out  1  write request to the AXI write master (cpu_aw_valid).
REQ-010 wr_ready  in  1  write master idle (cpu_aw_ready).
REQ-011 wr_id  out  ID_W  transaction ID; wr_addr  out  ADDR_W; wr_size  out  2; wr_data  out  DATA_W; wr_len  out  LEN_W.
REQ-012 wr_resp  in  2  registered B response from the write master.
REQ-013 ld_addr  in  ADDR_W  address of the pending load for the hazard check.
REQ-014 ld_conflict  out  1  pending load overlaps a buffered store; the load SHALL stall.
REQ-015 sb_empty  out  1  no entries held and no write in flight; used by fence.
REQ-016 sb_err  out  1  sticky flag for a non-OKAY write response.
REQ-017 err_clr  in  1  clears sb_err.

Function
REQ-018 The buffer SHALL be a circular FIFO of DEPTH entries {addr, size, data}, with read/write pointers of log2(DEPTH) bits that wrap, and a count of log2(DEPTH)+1 bits.
REQ-019 st_ready SHALL be (count != DEPTH), taken from registered count; a full buffer with a same-cycle pop SHALL still refuse the push.
REQ-020 A push on st_valid&&st_ready SHALL write the entry at wptr and increment wptr at the clock edge.
REQ-021 The issue FSM SHALL have states S_IDLE, S_REQ, S_BUSY and S_DONE.
REQ-022 S_IDLE SHALL go to S_REQ when count!=0.
REQ-023 S_REQ SHALL drive wr_valid=1, and SHALL go to S_BUSY when wr_valid&&wr_ready.
REQ-024 S_BUSY SHALL wait for wr_ready==0 (write master left idle) and then go to S_DONE.
REQ-025 S_DONE SHALL wait for wr_ready==1, and in that cycle SHALL sample wr_resp, pop the head entry and return to S_IDLE.
REQ-026 wr_addr, wr_size and wr_data SHALL equal the head entry, combinational from rptr, and SHALL stay stable from S_REQ through S_DONE.
REQ-027 wr_len SHALL be 0 (single beat) and wr_id SHALL be ID.
REQ-028 When push and pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-029 On pop with wr_resp!=2'b00, sb_err SHALL be set to 1; err_clr SHALL clear it; if both occur in the same cycle, set SHALL win.
REQ-030 sb_empty SHALL be (count==0 && state==S_IDLE).
REQ-031 Entries SHALL drain strictly in push order, one transaction at a time.

Reset
REQ-032 While reset_n==0 at a clock edge: pointers, count and sb_err SHALL be 0, state SHALL be S_IDLE, and wr_valid SHALL be 0.
REQ-033 Entry storage need not be reset.
REQ-034 A reset mid-transaction SHALL drop all entries; the write master is reset by the same reset_n.
REQ-035 After reset: st_ready=1, sb_empty=1, ld_conflict=0.

Configuration
REQ-036 Macro YSYX_22041071_SB_HAZARD_EN defined: ld_conflict SHALL be 1 iff any valid entry, including the in-flight head, has addr[ADDR_W-1:3]==ld_addr[ADDR_W-1:3].
REQ-037 Macro YSYX_22041071_SB_HAZARD_EN undefined: ld_conflict SHALL be (!sb_empty), so every load stalls until the buffer drains.

Verification
REQ-038 After reset, push {0x8000_0010, size 11, 0x1122334455667788} -> wr_valid=1 on the next cycle with wr_addr=0x8000_0010, wr_len=0 and wr_id=1; pop occurs once wr_ready has fallen and risen again; sb_empty=1 after the pop.
REQ-039 Hold wr_ready=0 and push 4 stores -> st_ready=0 after the 4th; a 5th st_valid is not accepted; releasing wr_ready drains the stores in push order.
REQ-040 Push and complete an issue in the same cycle at count=2 -> count stays 2 and wptr/rptr both advance; fill past wptr=3 to exercise pointer wrap -> order is preserved.
REQ-041 Complete a write with wr_resp=2'b10 -> sb_err=1 after the pop and stays 1 until err_clr; err_clr coinciding with a further error response -> sb_err stays 1.
REQ-042 With the macro defined, entry at 0x8000_0010 and ld_addr=0x8000_0014 -> ld_conflict=1; ld_addr=0x8000_0018 -> ld_conflict=0. With the macro undefined, either address -> ld_conflict=1 until drained.
REQ-043 Assert reset_n=0 in S_BUSY with 3 entries held -> next cycle count=0, wr_valid=0, st_ready=1.

Source files
------------

// File: rtl/ysyx_22041071_store_buf.sv
// Store buffer: circular FIFO of pending stores, drained one single-beat write at a time.
// YSYX_22041071_SB_HAZARD_EN: per-doubleword load hazard check instead of stalling loads until drained.
module ysyx_22041071_store_buf #(
  parameter int              DEPTH  = 4,
  parameter int              ADDR_W = 64,
  parameter int              DATA_W = 64,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] ID     = 4'd1,
  parameter int              LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [1:0]        st_size,
  input  logic [DATA_W-1:0] st_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ID_W-1:0]   wr_id,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_size,
  output logic [DATA_W-1:0] wr_data,
  output logic [LEN_W-1:0]  wr_len,
  input  logic [1:0]        wr_resp,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict,
  output logic              sb_empty,
  output logic              sb_err,
  input  logic              err_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_DONE} state_t;

  state_t            state_q;
  logic              wr_valid_q;
  logic              sb_err_q;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push, pop;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [1:0]        size_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // A full buffer refuses the push even if the head retires in the same cycle.
  assign st_ready = (count_q != (PTR_W+1)'(DEPTH));
  assign push     = st_valid && st_ready;
  assign pop      = (state_q == S_DONE) && wr_ready;

  always_comb begin
    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (PTR_W+1)'(1);
    else if (!push && pop)
      count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= st_addr;
      size_mem[wptr_q] <= st_size;
      data_mem[wptr_q] <= st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      sb_err_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (pop && (wr_resp != 2'b00))
        sb_err_q <= 1'b1;
      else if (err_clr)
        sb_err_q <= 1'b0;
    end
  end

  // BUSY/DONE follow the write master leaving idle and returning with its response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (count_q != '0) begin
          state_q    <= S_REQ;
          wr_valid_q <= 1'b1;
        end
        S_REQ: if (wr_ready) begin
          state_q    <= S_BUSY;
          wr_valid_q <= 1'b0;
        end
        S_BUSY: if (!wr_ready) state_q <= S_DONE;
        S_DONE: if (wr_ready) state_q <= S_IDLE;
        default: begin
          state_q    <= S_IDLE;
          wr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_id    = ID;
  assign wr_len   = '0;
  assign wr_addr  = addr_mem[rptr_q];
  assign wr_size  = size_mem[rptr_q];
  assign wr_data  = data_mem[rptr_q];
  assign sb_empty = (count_q == '0) && (state_q == S_IDLE);
  assign sb_err   = sb_err_q;

`ifdef YSYX_22041071_SB_HAZARD_EN
  logic [DEPTH-1:0] hit;

  // An entry is live when its distance from the head is below count; the head stays live until popped.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PTR_W-1:0] offset;
    assign offset  = PTR_W'(gi) - rptr_q;
    assign hit[gi] = ({1'b0, offset} < count_q) &&
                     (addr_mem[gi][ADDR_W-1:3] == ld_addr[ADDR_W-1:3]);
  end

  assign ld_conflict = |hit;
`else
  logic ld_addr_unused;

  assign ld_addr_unused = ^ld_addr;
  assign ld_conflict    = !sb_empty;
`endif

endmodule

// File: tb/tb_ysyx_22041071_store_buf.sv
// Randomized bench for the store buffer against a transaction-level queue model and a modelled write master.
module tb_ysyx_22041071_store_buf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid, st_ready;
  logic [63:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_id;
  logic [63:0] wr_addr, wr_data;
  logic [1:0]  wr_size, wr_resp;
  logic [7:0]  wr_len;
  logic [63:0] ld_addr;
  logic        ld_conflict, sb_empty, sb_err, err_clr;

  always #5 clk = ~clk;

  ysyx_22041071_store_buf dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id), .wr_addr(wr_addr), .wr_size(wr_size),
    .wr_data(wr_data), .wr_len(wr_len), .wr_resp(wr_resp),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict), .sb_empty(sb_empty), .sb_err(sb_err), .err_clr(err_clr)
  );

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } ent_t;

  ent_t q[$];          // stores accepted but not yet retired, in push order
  bit   inflight;      // head handed to the write master, response pending
  bit   exp_valid;
  bit   exp_err;
  int   busy_cnt;      // remaining cycles the modelled master keeps wr_ready low
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_conflict(input logic [63:0] la);
`ifdef YSYX_22041071_SB_HAZARD_EN
    foreach (q[i]) if (q[i].addr[63:3] == la[63:3]) return 1'b1;
    return 1'b0;
`else
    return q.size() != 0;
`endif
  endfunction

  // One clock: drive inputs, check outputs against the model, take the edge, advance the model.
  task automatic cycle(input bit sv, input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d,
                       input bit hold, input logic [1:0] resp, input bit clr, input logic [63:0] la,
                       input bit rst);
    bit push, hs, pop;
    int qs;
    ent_t e;
    st_valid = sv; st_addr = a; st_size = sz; st_data = d;
    wr_resp = resp; err_clr = clr; ld_addr = la; reset_n = !rst;
    wr_ready = inflight ? (busy_cnt == 0) : !hold;
    #1;
    qs = q.size();
    check("st_ready", st_ready, qs != DEPTH);
    check("sb_empty", sb_empty, qs == 0);
    check("wr_valid", wr_valid, exp_valid);
    check("sb_err", sb_err, exp_err);
    check("ld_conflict", ld_conflict, exp_conflict(la));
    if ((exp_valid || inflight) && qs != 0) begin
      check("wr_addr", wr_addr, q[0].addr);
      check("wr_size", wr_size, q[0].size);
      check("wr_data", wr_data, q[0].data);
      check("wr_len", wr_len, 0);
      check("wr_id", wr_id, 1);
    end
    push = sv && (qs != DEPTH);
    hs   = exp_valid && wr_ready;
    pop  = inflight && (busy_cnt == 0);
    @(posedge clk); #1;
    if (rst) begin
      q.delete(); inflight = 0; exp_valid = 0; exp_err = 0; busy_cnt = 0;
    end else begin
      exp_valid = !inflight && !hs && (qs > 0);
      if (pop) begin
        $display("write done addr=%h size=%0d data=%h resp=%0d", q[0].addr, q[0].size, q[0].data, resp);
        exp_err = (resp != 2'b00) ? 1'b1 : (clr ? 1'b0 : exp_err);
        void'(q.pop_front());
        inflight = 0;
      end else if (clr) begin
        exp_err = 0;
      end
      if (inflight && busy_cnt > 0) busy_cnt--;
      if (hs) begin
        inflight = 1;
        busy_cnt = $urandom_range(1, 3);
      end
      if (push) begin
        e.addr = a; e.size = sz; e.data = d;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input bit hold);
    cycle(0, 0, 0, 0, hold, 2'b00, 0, 0, 0);
  endtask

  task automatic push_one(input logic [63:0] a, input bit hold);
    cycle(1, a, 2'($urandom_range(0, 3)), {$urandom, $urandom}, hold, 2'b00, 0, 0, 0);
  endtask

  // Run with the given response until empty; optionally pulse err_clr exactly on each retire edge.
  task automatic drain(input logic [1:0] resp, input bit clr_at_pop);
    for (int i = 0; i < 300 && (q.size() != 0 || inflight); i++)
      cycle(0, 0, 0, 0, 0, resp, clr_at_pop && inflight && busy_cnt == 0, 0, 0);
    check("drain_bound", q.size(), 0);
  endtask

  initial begin
    inflight = 0; exp_valid = 0; exp_err = 0; busy_cnt = 0;
    reset_n = 0; st_valid = 0; st_addr = 0; st_size = 0; st_data = 0;
    wr_ready = 1; wr_resp = 0; err_clr = 0; ld_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_st_ready", st_ready, 1);
    check("reset_sb_empty", sb_empty, 1);
    check("reset_ld_conflict", ld_conflict, 0);
    check("reset_wr_valid", wr_valid, 0);
    check("reset_sb_err", sb_err, 0);

    // Single doubleword store through the whole handshake.
    cycle(1, 64'h8000_0010, 2'b11, 64'h1122_3344_5566_7788, 0, 2'b00, 0, 0, 0);
    idle(0);
    check("first_wr_valid", wr_valid, 1);
    check("first_wr_addr", wr_addr, 64'h8000_0010);
    drain(2'b00, 0);
    check("first_sb_empty", sb_empty, 1);

    // Fill with the master held idle-low, try a fifth store, then drain in order.
    for (int i = 0; i < 4; i++) push_one(64'h8000_0100 + 64'(i * 8), 1);
    check("full_st_ready", st_ready, 0);
    push_one(64'h8000_0200, 1);
    check("full_no_accept", q.size(), DEPTH);
    drain(2'b00, 0);

    // Keep two entries and push on every retire edge so the pointers wrap repeatedly.
    for (int i = 0; i < 2; i++) push_one(64'h8000_0300 + 64'(i * 8), 1);
    for (int i = 0; i < 60; i++)
      cycle(inflight && busy_cnt == 0, 64'h8000_0400 + 64'(i * 8), 2'b10, {$urandom, $urandom},
            0, 2'b00, 0, 0, 0);
    check("steady_count", q.size(), 2);
    drain(2'b00, 0);

    // Error response is sticky; clearing on the same edge as a new error leaves it set.
    push_one(64'h8000_0500, 0);
    drain(2'b10, 0);
    check("err_set", sb_err, 1);
    idle(0); idle(0);
    check("err_sticky", sb_err, 1);
    cycle(0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
    check("err_cleared", sb_err, 0);
    push_one(64'h8000_0508, 0);
    drain(2'b10, 1);
    check("err_set_wins", sb_err, 1);
    cycle(0, 0, 0, 0, 0, 2'b00, 1, 0, 0);

    // Load hazard against a held entry.
    cycle(1, 64'h8000_0010, 2'b11, 64'hdead_beef, 1, 2'b00, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 2'b00, 0, 64'h8000_0014, 0);
    check("haz_same_dword", ld_conflict, 1);
    cycle(0, 0, 0, 0, 1, 2'b00, 0, 64'h8000_0018, 0);
`ifdef YSYX_22041071_SB_HAZARD_EN
    check("haz_next_dword", ld_conflict, 0);
`else
    check("haz_next_dword", ld_conflict, 1);
`endif
    drain(2'b00, 0);

    // Reset while the head is in flight with three entries held.
    for (int i = 0; i < 3; i++) push_one(64'h8000_0600 + 64'(i * 8), 1);
    for (int i = 0; i < 20 && !inflight; i++) idle(0);
    check("busy_reached", inflight, 1);
    cycle(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_st_ready", st_ready, 1);
    check("rst_sb_empty", sb_empty, 1);

    // Random traffic with addresses packed into a few doublewords to provoke hazards.
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 1) == 1, 64'h8000_0000 + 64'($urandom_range(0, 47)),
            2'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00, $urandom_range(0, 15) == 0,
            64'h8000_0000 + 64'($urandom_range(0, 47)), 0);
    drain(2'b00, 0);
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
